// File: rtl/ascii_pkg.sv
// ascii_pkg
//   Shared constants and types for the ASCII case-folding stream blocks.
//   - ASCII_UPPER_A / ASCII_UPPER_Z : inclusive range of uppercase letters
//   - ASCII_LOWER_A / ASCII_LOWER_Z : inclusive range of lowercase letters
//   - ASCII_CASE_BIT                : bit that distinguishes upper from lower case
//   - skid_state_t                  : occupancy state of the 2-entry skid buffer
package ascii_pkg;

  localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam int         ASCII_CASE_BIT = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // True for 'A'..'Z' only; bytes >= 0x80 are never letters.
  function automatic logic is_upper_letter(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

endpackage

// File: rtl/byte_skid_buffer.sv
// byte_skid_buffer
//   Generic 8-bit, 2-entry valid/ready skid buffer. All handshake outputs are
//   registered, so there is no combinational path from out_ready to in_ready.
//   Ports:
//     clk       : clock, all state changes on the rising edge
//     rst       : synchronous active-high reset, empties the buffer
//     in_data   : byte offered by the upstream side
//     in_valid  : upstream byte valid
//     in_ready  : buffer can take a byte this cycle (registered)
//     out_data  : head byte (registered, stable while stalled)
//     out_valid : head byte valid (registered)
//     out_ready : downstream takes the head byte this cycle
module byte_skid_buffer
  import ascii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  skid_state_t state;
  logic [7:0]  head;
  logic [7:0]  tail;
  logic        push;
  logic        pop;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = head;

  // Occupancy FSM. in_ready/out_valid are registered alongside the state so
  // they always reflect the state being entered. Head is what the consumer
  // sees; tail only holds the byte that arrived while the head was stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= 8'h00;
      tail      <= 8'h00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head      <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail     <= in_data;
              state    <= TWO;
              in_ready <= 1'b0;
            end
            2'b01: begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
            2'b11: begin
              // Head leaves and the new byte replaces it in the same cycle.
              head <= in_data;
            end
            default: begin
            end
          endcase
        end
        TWO: begin
          if (pop) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ascii_tolower_stream.sv
// ascii_tolower_stream
//   Streaming ASCII lowercase converter. 'A'..'Z' get the case bit set, every
//   other byte passes unchanged. Output is registered behind a 2-entry skid
//   buffer; a saturating counter tracks how many bytes were actually modified.
//   Ports:
//     clk        : clock
//     rst        : synchronous active-high reset
//     in_data    : input byte
//     in_valid   : input byte valid
//     in_ready   : block can accept a byte this cycle
//     bypass     : sampled with each accepted byte, 1 = pass byte unmodified
//     out_data   : converted byte
//     out_valid  : out_data valid
//     out_ready  : downstream accepts out_data this cycle
//     cnt_clr    : synchronous clear of the letter counter (wins over increment)
//     letter_cnt : saturating count of modified bytes
module ascii_tolower_stream
  import ascii_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter bit BYPASS_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bypass,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] letter_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       bypass_q;
  logic       eff_bypass;
  logic       conv;
  logic       push;
  logic [7:0] conv_data;

  // Idle cycles present the mode of the last accepted byte, so the conversion
  // path does not follow a floating bypass pin while nothing is transferred.
  assign eff_bypass = in_valid ? bypass : bypass_q;
  assign conv       = is_upper_letter(in_data) && !eff_bypass;
  assign conv_data  = in_data | (8'(conv) << ASCII_CASE_BIT);
  assign push       = in_valid && in_ready;

  // Remembers the bypass mode that came with the most recent accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= BYPASS_DEFAULT;
    end else if (push) begin
      bypass_q <= bypass;
    end
  end

  // Saturating counter of modified bytes; a clear drops any same-cycle letter.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      letter_cnt <= '0;
    end else if (push && conv && (letter_cnt != CNT_MAX)) begin
      letter_cnt <= letter_cnt + CNT_W'(1);
    end
  end

  byte_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (conv_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
